// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (AND/ADD/SUB/CMP, bit-serial shifts, shift-add MUL); done pulses one cycle, start ignored while busy.
// Define ALU_MC_MUL_EN to build the iterative multiplier; otherwise op 7 completes via EXEC with result 0.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  localparam int MSB = WIDTH - 1;
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

`ifdef ALU_MC_MUL_EN
  typedef enum logic [2:0] {IDLE, EXEC, SHIFT, MUL, DONE} stateT;
`else
  typedef enum logic [2:0] {IDLE, EXEC, SHIFT, DONE} stateT;
`endif

  stateT            state;
  logic [2:0]       opCode;
  logic [WIDTH-1:0] opA, opB, work;
  logic [CNT_W-1:0] cnt, amt;
  logic [WIDTH:0]   addSum, subSum;
  logic [WIDTH-1:0] execRes, shNext;
  logic             execC, execV, shBit, isShift;

  assign amt     = (b[CNT_W-1:0] > WIDTH_CNT) ? WIDTH_CNT : b[CNT_W-1:0];
  assign isShift = (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
  assign addSum  = {1'b0, opA} + {1'b0, opB};
  assign subSum  = {1'b0, opA} + {1'b0, ~opB} + (WIDTH+1)'(1);

  always_comb begin
    execRes = '0;
    execC   = 1'b0;
    execV   = 1'b0;
    case (opCode)
      3'd0: execRes = opA & opB;
      3'd1: begin
        execRes = addSum[MSB:0];
        execC   = addSum[WIDTH];
        execV   = (opA[MSB] == opB[MSB]) && (addSum[MSB] != opA[MSB]);
      end
      // SUB and CMP report borrow, i.e. the inverted carry-out
      3'd2, 3'd3: begin
        execRes = subSum[MSB:0];
        execC   = ~subSum[WIDTH];
        execV   = (opA[MSB] != opB[MSB]) && (subSum[MSB] != opA[MSB]);
      end
      3'd4, 3'd5, 3'd6: execRes = opA;
      default: execRes = '0;
    endcase
  end

  always_comb begin
    shNext = {work[MSB-1:0], 1'b0};
    shBit  = work[MSB];
    if (opCode == 3'd5) begin
      shNext = {1'b0, work[MSB:1]};
      shBit  = work[0];
    end else if (opCode == 3'd6) begin
      shNext = {work[MSB], work[MSB:1]};
      shBit  = work[0];
    end
  end

`ifdef ALU_MC_MUL_EN
  // work holds the high product half, opB the low half as the multiplier shifts out
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi, mulLo;
  assign mulSum = {1'b0, work} + (opB[0] ? {1'b0, opA} : '0);
  assign mulHi  = mulSum[WIDTH:1];
  assign mulLo  = {mulSum[0], opB[MSB:1]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
      zero     <= 1'b0;
      opCode   <= '0;
      opA      <= '0;
      opB      <= '0;
      work     <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (start) begin
            opCode <= op;
            opA    <= a;
            opB    <= b;
            work   <= a;
            cnt    <= amt;
            busy   <= 1'b1;
            if (isShift && amt != '0) begin
              state <= SHIFT;
`ifdef ALU_MC_MUL_EN
            end else if (op == 3'd7) begin
              state <= MUL;
              work  <= '0;
              cnt   <= WIDTH_CNT;
`endif
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          if (opCode != 3'd3) result <= execRes;
          carry    <= execC;
          overflow <= execV;
          negative <= execRes[MSB];
          zero     <= (execRes == '0);
        end
        SHIFT: begin
          work <= shNext;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= shNext;
            carry    <= shBit;
            overflow <= 1'b0;
            negative <= shNext[MSB];
            zero     <= (shNext == '0);
          end
        end
`ifdef ALU_MC_MUL_EN
        MUL: begin
          work <= mulHi;
          opB  <= mulLo;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= mulLo;
            carry    <= |mulHi;
            overflow <= 1'b0;
            negative <= mulLo[MSB];
            zero     <= (mulLo == '0);
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32; flags compared as {carry, overflow, negative, zero}.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, done;
  logic        carry, overflow, negative, zero;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carry(carry), .overflow(overflow), .negative(negative), .zero(zero)
  );

  function automatic logic [3:0] flags();
    return {carry, overflow, negative, zero};
  endfunction

  // Start in cycle 0, return the cycle in which done is seen (-1 on timeout).
  // A nonzero poke re-asserts start (op AND, zero operands) during that busy cycle.
  task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int poke, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = (c == poke);
      if (c == poke) begin op = 3'd0; a = '0; b = '0; end
      if (done) begin lat = c; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vecs++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL reset_ctl: got %b want 00", {busy, done}); end
    vecs++; if (result !== 32'h0) begin errs++; $display("FAIL reset_result: got %h want 0", result); end
    vecs++; if (flags() !== 4'b0000) begin errs++; $display("FAIL reset_flags: got %b want 0000", flags()); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    runOp(3'd1, 32'hFFFF_FFFF, 32'h1, 0, lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL add_lat: got %0d want 2", lat); end
    vecs++; if (result !== 32'h0) begin errs++; $display("FAIL add_result: got %h want 0", result); end
    vecs++; if (flags() !== 4'b1001) begin errs++; $display("FAIL add_flags: got %b want 1001", flags()); end
  endtask

  task automatic test_sub_cmp();
    int lat;
    runOp(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL sub_lat: got %0d want 2", lat); end
    vecs++; if (result !== 32'h8000_0000) begin errs++; $display("FAIL sub_result: got %h want 80000000", result); end
    vecs++; if (flags() !== 4'b1110) begin errs++; $display("FAIL sub_flags: got %b want 1110", flags()); end
    runOp(3'd3, 32'h5, 32'h5, 0, lat);
    vecs++; if (result !== 32'h8000_0000) begin errs++; $display("FAIL cmp_result: got %h want 80000000", result); end
    vecs++; if (flags() !== 4'b0001) begin errs++; $display("FAIL cmp_flags: got %b want 0001", flags()); end
  endtask

  task automatic test_shift();
    int lat;
    runOp(3'd6, 32'h8000_0001, 32'h4, 2, lat);
    vecs++; if (lat !== 5) begin errs++; $display("FAIL sra_lat: got %0d want 5", lat); end
    vecs++; if (result !== 32'hF800_0000) begin errs++; $display("FAIL sra_result: got %h want f8000000", result); end
    vecs++; if (flags() !== 4'b0010) begin errs++; $display("FAIL sra_flags: got %b want 0010", flags()); end
    @(negedge clk);
    vecs++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL sra_idle_after: got %b want 00", {busy, done}); end
    runOp(3'd4, 32'h0000_1234, 32'h0, 0, lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL sll0_lat: got %0d want 2", lat); end
    vecs++; if ({result, flags()} !== {32'h0000_1234, 4'b0000}) begin errs++; $display("FAIL sll0_out: got %h/%b want 00001234/0000", result, flags()); end
    runOp(3'd5, 32'h8000_0000, 32'd40, 0, lat);
    vecs++; if (lat !== 33) begin errs++; $display("FAIL srl_clamp_lat: got %0d want 33", lat); end
    vecs++; if ({result, flags()} !== {32'h0, 4'b1001}) begin errs++; $display("FAIL srl_clamp_out: got %h/%b want 00000000/1001", result, flags()); end
    runOp(3'd6, 32'h8000_0000, 32'd63, 0, lat);
    vecs++; if ({result, flags()} !== {32'hFFFF_FFFF, 4'b1010}) begin errs++; $display("FAIL sra_clamp_out: got %h/%b want ffffffff/1010", result, flags()); end
  endtask

  task automatic test_mul();
    int lat;
    runOp(3'd7, 32'h0001_0000, 32'h0001_0001, 0, lat);
`ifdef ALU_MC_MUL_EN
    vecs++; if (lat !== 33) begin errs++; $display("FAIL mul_lat: got %0d want 33", lat); end
    vecs++; if (result !== 32'h0001_0000) begin errs++; $display("FAIL mul_result: got %h want 00010000", result); end
    vecs++; if (flags() !== 4'b1000) begin errs++; $display("FAIL mul_flags: got %b want 1000", flags()); end
`else
    vecs++; if (lat !== 2) begin errs++; $display("FAIL mul_lat: got %0d want 2", lat); end
    vecs++; if (result !== 32'h0) begin errs++; $display("FAIL mul_result: got %h want 0", result); end
    vecs++; if (flags() !== 4'b0001) begin errs++; $display("FAIL mul_flags: got %b want 0001", flags()); end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    runOp(3'd1, 32'h1, 32'h2, 0, lat);
    vecs++; if ({lat, result} !== {32'd2, 32'h3}) begin errs++; $display("FAIL b2b_first: got lat %0d res %h want 2/3", lat, result); end
    start = 1'b1; op = 3'd0; a = 32'h0000_F0F0; b = 32'h0000_FF00;
    @(negedge clk);
    start = 1'b0;
    vecs++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL b2b_accept: got %b want 10", {busy, done}); end
    @(negedge clk);
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL b2b_done: got %b want 1", done); end
    vecs++; if ({result, flags()} !== {32'h0000_F000, 4'b0000}) begin errs++; $display("FAIL b2b_result: got %h/%b want 0000f000/0000", result, flags()); end
  endtask

  task automatic test_reset_midop();
    int doneCnt;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1; b = 32'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0; start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    vecs++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL rst_mid_ctl: got %b want 00", {busy, done}); end
    vecs++; if ({result, flags()} !== {32'h0, 4'b0000}) begin errs++; $display("FAIL rst_mid_out: got %h/%b want 00000000/0000", result, flags()); end
    start = 1'b0; rst_n = 1'b1;
    doneCnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) doneCnt++;
    end
    vecs++; if (doneCnt !== 0) begin errs++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", doneCnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand/result width (legal 8..64).
REQ-002 SHALL have parameter CNT_W, default 6, meaning the shift/iteration counter width (must satisfy 2^CNT_W > WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL have port op  input  3  operation code: 0 AND, 1 ADD, 2 SUB, 3 CMP, 4 SLL, 5 SRL, 6 SRA, 7 MUL.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B; shift amount is b[CNT_W-1:0] saturated to WIDTH.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports carry, overflow, negative, zero  output  1 each  registered flags.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, SHIFT, MUL, DONE; busy=1 exactly in EXEC, SHIFT, MUL.
REQ-014 SHALL accept start in IDLE or DONE, capturing a, b, op that edge; start while busy=1 SHALL be ignored.
REQ-015 SHALL route AND/ADD/SUB/CMP to EXEC, SLL/SRL/SRA with amount>0 to SHIFT, amount=0 to EXEC, MUL to MUL.
REQ-016 SHALL take one cycle in EXEC, one cycle per bit position in SHIFT, WIDTH cycles in MUL, then enter DONE.
REQ-017 SHALL make latency start-edge to done-high: 2 cycles for EXEC ops, amount+1 for shifts, WIDTH+1 for MUL.
REQ-018 SHALL assert done for exactly one cycle in DONE, then return to IDLE unless a new start is accepted.
REQ-019 SHALL update result and all flags only in the cycle entering DONE; they hold until the next completion.
REQ-020 ADD/SUB SHALL give WIDTH-bit two's-complement result (SUB not converted to magnitude); carry = carry-out for ADD, borrow (inverted carry-out) for SUB/CMP; overflow = signed overflow.
REQ-021 CMP SHALL update flags as SUB but SHALL leave result unchanged.
REQ-022 Shifts SHALL shift one bit per cycle; SRA replicates the MSB; carry = last bit shifted out (0 for amount 0); overflow=0.
REQ-023 AND SHALL set carry=0, overflow=0.
REQ-024 negative SHALL equal result MSB (SUB value for CMP); zero SHALL be 1 when that value equals 0.
REQ-025 Shift amount ≥WIDTH SHALL be clamped to WIDTH (SLL/SRL yield 0; SRA yields all MSB).

Reset
REQ-026 With rst_n=0 at a rising edge, state SHALL become IDLE and busy, done, result, all flags SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL abort it with no done pulse; start is ignored while rst_n=0.

Configuration
REQ-028 Macro ALU_MC_MUL_EN defined: op 7 SHALL perform iterative shift-add unsigned multiply, result = low WIDTH bits, carry = 1 if any upper-half bit nonzero, overflow=0.
REQ-029 ALU_MC_MUL_EN undefined: MUL state SHALL be absent; op 7 SHALL go via EXEC, giving result=0, zero=1, other flags 0, latency 2.

Verification
REQ-030 Reset: rst_n=0 mid-SHIFT (SLL, amount 20) -> next cycle busy=0, done=0, result=0, flags 0; no later done.
REQ-031 ADD WIDTH=32: a=0xFFFFFFFF, b=1 -> done at cycle 2, result=0, carry=1, zero=1, overflow=0.
REQ-032 SUB: a=0x7FFFFFFF, b=0xFFFFFFFF -> result=0x80000000, overflow=1, negative=1, carry=1; then CMP a=5,b=5 -> zero=1, result still 0x80000000.
REQ-033 SRA: a=0x80000001, b=4 -> done at cycle 5, result=0xF8000000, carry=0; start pulsed during busy ignored.
REQ-034 MUL (ALU_MC_MUL_EN): a=0x00010000, b=0x00010001 -> done at cycle 33, result=0x00010000, carry=1; without macro -> result=0, zero=1 at cycle 2.
REQ-035 Back-to-back: start held high in DONE with op=AND, a=0xF0F0, b=0xFF00 -> accepted, result=0xF000 two cycles later.
